pool_bank_scheduler: RTL and testbench
======================================

POOL_BANK_SCHEDULER -- requirements
Module: pool_bank_scheduler

Interface
REQ-001 The block SHALL have parameter GRAPH_SIZE, default 16, meaning pooled graph side length.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32*PRECISION+18, meaning bank word width.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default $clog2(GRAPH_SIZE*GRAPH_SIZE), meaning bank address width.
REQ-004 The block SHALL have these ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low.
- mp_ena  in  1  maxpool port enable.
- mp_wea  in  1  maxpool write enable.
- mp_addr  in  ADDR_WIDTH  maxpool address.
- mp_write  in  DATA_WIDTH  maxpool write data.
- mp_read  out  DATA_WIDTH  bank read data to maxpool (bram_rdata passed through).
- scan_start  in  1  pulse: drain this bank.
- scan_busy  out  1  drain in progress.
- scan_done  out  1  one-cycle pulse after the last word.
- out_valid  out  1  drained word valid.
- out_ready  in  1  consumer accepts.
- out_addr  out  ADDR_WIDTH  drained word address.
- out_data  out  DATA_WIDTH  drained word.
- bram_ena, bram_wea  out  1  bank port controls.
- bram_addr  out  ADDR_WIDTH  bank port address.
- bram_wdata  out  DATA_WIDTH  bank port write data.
- bram_rdata  in  DATA_WIDTH  bank port read data (1-cycle latency).

Function
REQ-005 Port mux SHALL be combinational: when mp_ena=1, bram_* follow mp_*; otherwise bram_* are driven by the scanner; the maxpool is never stalled.
REQ-006 Scanner FSM SHALL have states IDLE, RD, CAP, CLR, OUT, DONE.
REQ-007 IDLE->RD on scan_start=1; scan_start SHALL be ignored in every other state; the address counter is loaded with 0 on entry to RD from IDLE.
REQ-008 RD: the scanner SHALL issue a read (ena=1, wea=0) at the counter address only in a cycle with mp_ena=0, then go to CAP; otherwise it stays in RD.
REQ-009 CAP: the scanner SHALL register bram_rdata into out_data and the counter into out_addr, then go to CLR.
REQ-010 CLR: the scanner SHALL write all-zero data to the counter address in a cycle with mp_ena=0, then go to OUT; otherwise it stays in CLR.
REQ-011 Hazard: if mp_ena=1 and mp_wea=1 with mp_addr equal to the counter address in any cycle from the RD issue through CLR (the CLR issue cycle included), the scanner SHALL discard the capture and return to RD for the same address.
REQ-012 OUT: out_valid=1 and out_data/out_addr held stable until out_valid and out_ready are both high; on that transfer the counter increments; at address GRAPH_SIZE^2-1 it goes to DONE, else to RD.
REQ-013 DONE: scan_done=1 for exactly one cycle, then IDLE; scan_busy=1 in every state except IDLE.
REQ-014 Minimum throughput SHALL be one word per 4 cycles (RD, CAP, CLR, OUT with out_ready=1 and mp_ena=0).

Reset
REQ-015 With reset=0 at a clock edge the FSM SHALL go to IDLE and the counter, out_valid, out_addr, out_data, scan_busy and scan_done SHALL all be 0; reset mid-scan SHALL abandon the scan with no further bank writes.

Configuration
REQ-016 With POOL_SKIP_EMPTY_EN defined, a captured word whose bit 4 (the self-loop/occupied edge) is 0 SHALL skip CLR and OUT: the counter increments, or the FSM goes to DONE at the last address.
REQ-017 Without POOL_SKIP_EMPTY_EN, every address SHALL be presented on out_* and cleared.

Structure
REQ-018 The scanner state enum and the bit index of the occupied flag (4) SHALL be placed in graph_pkg.
REQ-019 The design SHALL be a single module with no sub-modules.

Verification
REQ-020 Bench: GRAPH_SIZE=4, bank preloaded with addr+1, out_ready=1, no maxpool traffic, scan_start pulse -> 16 words, out_addr 0..15 in order, data addr+1; scan_done 64 cycles after start; bank all zero afterwards.
REQ-021 Bench: mp_ena held 1 for 10 cycles during RD -> no scanner port access during those cycles; the scan completes correctly afterwards.
REQ-022 Bench: maxpool writes 0xAB to address 5 while the scanner is in CAP for address 5 -> word 5 is re-read and out_data contains 0xAB.
REQ-023 Bench: out_ready=0 for 20 cycles in OUT -> out_valid stays 1 and out_data/out_addr stay stable.
REQ-024 Bench: POOL_SKIP_EMPTY_EN defined, only addresses 3 and 9 have bit 4 set -> exactly 2 transfers, on addresses 3 and 9.
REQ-025 Bench: reset=0 asserted at address 7 -> all outputs 0 and no further writes to the bank; a scan_start pulse after reset releases begins again at address 0.

Source files
------------

// File: rtl/graph_pkg.sv
// Shared types and constants for the pooled-graph bank scheduler.
// Holds the scanner state encoding and the occupied-flag bit position.
package graph_pkg;

    localparam int unsigned PRECISION = 1;
    localparam int unsigned OCC_BIT   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_CLR,
        S_OUT,
        S_DONE
    } scan_state_e;

endpackage

// File: rtl/pool_bank_scheduler_if.sv
// Drained-word valid/ready stream of pool_bank_scheduler, bundled for consumers.
interface pool_bank_scheduler_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 50
);
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (output out_valid, output out_addr, output out_data, input out_ready);
    modport slave  (input out_valid, input out_addr, input out_data, output out_ready);
endinterface

// File: rtl/pool_bank_scheduler.sv
// Shares one bank port between the maxpool (priority) and a read-clear-drain scanner.
// Optional feature: define POOL_SKIP_EMPTY_EN to skip words whose occupied flag is 0.
module pool_bank_scheduler
    import graph_pkg::*;
#(
    parameter int unsigned GRAPH_SIZE = 16,
    parameter int unsigned DATA_WIDTH = 32*PRECISION+18,
    parameter int unsigned ADDR_WIDTH = $clog2(GRAPH_SIZE*GRAPH_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mp_ena,
    input  logic                  mp_wea,
    input  logic [ADDR_WIDTH-1:0] mp_addr,
    input  logic [DATA_WIDTH-1:0] mp_write,
    output logic [DATA_WIDTH-1:0] mp_read,
    input  logic                  scan_start,
    output logic                  scan_busy,
    output logic                  scan_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  bram_ena,
    output logic                  bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    input  logic [DATA_WIDTH-1:0] bram_rdata
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(GRAPH_SIZE*GRAPH_SIZE-1);

    scan_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  scan_ena, scan_wea, hazard;

    // A maxpool write to the word in flight invalidates the capture.
    assign hazard = mp_ena && mp_wea && (mp_addr == cnt_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        scan_ena   = 1'b0;
        scan_wea   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (scan_start) begin
                    state_d = S_RD;
                    cnt_d   = '0;
                end
            end
            S_RD: begin
                if (!mp_ena) begin
                    scan_ena = 1'b1;
                    state_d  = S_CAP;
                end
            end
            S_CAP: begin
                if (hazard) begin
                    state_d = S_RD;
                end else begin
`ifdef POOL_SKIP_EMPTY_EN
                    if (!bram_rdata[OCC_BIT]) begin
                        if (cnt_q == LAST_ADDR) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = S_RD;
                        end
                    end else begin
                        out_data_d = bram_rdata;
                        out_addr_d = cnt_q;
                        state_d    = S_CLR;
                    end
`else
                    out_data_d = bram_rdata;
                    out_addr_d = cnt_q;
                    state_d    = S_CLR;
`endif
                end
            end
            S_CLR: begin
                if (hazard) begin
                    state_d = S_RD;
                end else if (!mp_ena) begin
                    scan_ena = 1'b1;
                    scan_wea = 1'b1;
                    state_d  = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_RD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end

    // Scanner access is suppressed while reset is held so an abandoned clear never lands.
    always_comb begin
        if (mp_ena) begin
            bram_ena   = 1'b1;
            bram_wea   = mp_wea;
            bram_addr  = mp_addr;
            bram_wdata = mp_write;
        end else begin
            bram_ena   = scan_ena && reset;
            bram_wea   = scan_wea && reset;
            bram_addr  = cnt_q;
            bram_wdata = '0;
        end
    end

    assign mp_read   = bram_rdata;
    assign out_valid = (state_q == S_OUT);
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign scan_busy = (state_q != S_IDLE);
    assign scan_done = (state_q == S_DONE);

endmodule

// File: tb/tb_pool_bank_scheduler.sv
// Scoreboard bench for pool_bank_scheduler on a 4x4 graph with a behavioural bank.
// Build with POOL_SKIP_EMPTY_EN defined to exercise the empty-word skip path.
module tb_pool_bank_scheduler;
    import graph_pkg::*;

    localparam int GS = 4;
    localparam int AW = 4;
    localparam int DW = 50;
    localparam int NW = 16;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          mp_ena = 1'b0, mp_wea = 1'b0;
    logic [AW-1:0] mp_addr = '0;
    logic [DW-1:0] mp_write = '0;
    logic [DW-1:0] mp_read;
    logic          scan_start = 1'b0, scan_busy, scan_done;
    logic          bram_ena, bram_wea;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata, bram_rdata;

    pool_bank_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) oif ();

    pool_bank_scheduler #(
        .GRAPH_SIZE(GS),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset),
        .mp_ena(mp_ena), .mp_wea(mp_wea), .mp_addr(mp_addr),
        .mp_write(mp_write), .mp_read(mp_read),
        .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done),
        .out_valid(oif.out_valid), .out_ready(oif.out_ready),
        .out_addr(oif.out_addr), .out_data(oif.out_data),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-first single-port bank, one-cycle read latency.
    logic [DW-1:0] mem [NW];
    always @(posedge clk) begin
        if (bram_ena) begin
            bram_rdata <= mem[bram_addr];
            if (bram_wea) mem[bram_addr] <= bram_wdata;
        end
    end

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int xfers = 0;
    int scan_wr = 0;

    always @(negedge clk) begin
        exp_t e;
        if (oif.out_valid && oif.out_ready) begin
            xfers++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL xfer_unexpected got addr=%0d data=%0h required none", oif.out_addr, oif.out_data);
            end else begin
                e = exp_q.pop_front();
                if (oif.out_addr !== e.a || oif.out_data !== e.d) begin
                    failures++;
                    $display("FAIL xfer got addr=%0d data=%0h required addr=%0d data=%0h",
                             oif.out_addr, oif.out_data, e.a, e.d);
                end
            end
        end
        if (mp_ena) begin
            checks++;
            if (bram_ena !== 1'b1 || bram_wea !== mp_wea || bram_addr !== mp_addr || bram_wdata !== mp_write) begin
                failures++;
                $display("FAIL port_mux got ena=%b wea=%b addr=%0d required ena=1 wea=%b addr=%0d",
                         bram_ena, bram_wea, bram_addr, mp_wea, mp_addr);
            end
        end
        if (bram_ena && bram_wea && !mp_ena) scan_wr++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, expv);
        end
    endtask

    task automatic mp_wr(input int a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        mp_ena = 1'b1; mp_wea = 1'b1; mp_addr = AW'(a); mp_write = d;
        @(posedge clk); #1;
        mp_ena = 1'b0; mp_wea = 1'b0;
    endtask

    task automatic mp_rd(input int a, output logic [DW-1:0] d);
        @(posedge clk); #1;
        mp_ena = 1'b1; mp_wea = 1'b0; mp_addr = AW'(a);
        @(posedge clk); #1;
        mp_ena = 1'b0;
        d = mp_read;
    endtask

    task automatic preload(input int mode);
        for (int a = 0; a < NW; a++) begin
            if (mode == 0) mp_wr(a, DW'(a + 1));
            else mp_wr(a, (a == 3 || a == 9) ? DW'(32'h10 | a) : DW'(a));
        end
    endtask

    task automatic push_plain();
        for (int a = 0; a < NW; a++) exp_q.push_back('{a: AW'(a), d: DW'(a + 1)});
    endtask

    task automatic start_scan(output int t0);
        @(posedge clk); #1;
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int max_cyc, output int done_at);
        int ok = 0;
        done_at = -1;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (scan_done) begin
                ok = 1;
                done_at = cyc;
                break;
            end
        end
        check("scan_done_seen", 64'(ok), 64'd1);
        @(negedge clk);
        check("scan_done_one_cycle", 64'(scan_done), 64'd0);
        check("busy_after_done", 64'(scan_busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(oif.out_valid), 64'd0);
        check({tag, "_out_addr"},  64'(oif.out_addr),  64'd0);
        check({tag, "_out_data"},  64'(oif.out_data),  64'd0);
        check({tag, "_scan_busy"}, 64'(scan_busy),     64'd0);
        check({tag, "_scan_done"}, 64'(scan_done),     64'd0);
    endtask

    initial begin
        int t0, td, nz, w0, x0, vcnt;
        logic [DW-1:0] rd;

        oif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        reset = 1'b1;

`ifdef POOL_SKIP_EMPTY_EN
        preload(1);
        exp_q.push_back('{a: AW'(3), d: DW'(32'h13)});
        exp_q.push_back('{a: AW'(9), d: DW'(32'h19)});
        x0 = xfers;
        start_scan(t0);
        wait_done(200, td);
        check("skip_xfer_count", 64'(xfers - x0), 64'd2);
        check("skip_queue_empty", 64'(exp_q.size()), 64'd0);
        mp_rd(3, rd); check("skip_mem3_cleared", 64'(rd), 64'd0);
        mp_rd(9, rd); check("skip_mem9_cleared", 64'(rd), 64'd0);
        mp_rd(4, rd); check("skip_mem4_kept", 64'(rd), 64'd4);
`else
        // Plain drain: 4 cycles per word.
        preload(0);
        push_plain();
        start_scan(t0);
        @(negedge clk);
        check("busy_after_start", 64'(scan_busy), 64'd1);
        wait_done(200, td);
        check("drain_latency", 64'(td - t0), 64'd64);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        nz = 0;
        for (int a = 0; a < NW; a++) begin
            mp_rd(a, rd);
            if (rd != '0) nz++;
        end
        check("bank_cleared", 64'(nz), 64'd0);

        // Maxpool holds the port for 10 cycles while scanner sits in RD.
        preload(0);
        push_plain();
        start_scan(t0);
        mp_ena = 1'b1; mp_wea = 1'b0; mp_addr = AW'(12);
        w0 = scan_wr;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (oif.out_valid) vcnt++;
        end
        @(posedge clk); #1;
        mp_ena = 1'b0;
        check("stall_no_valid", 64'(vcnt), 64'd0);
        check("stall_no_scan_write", 64'(scan_wr - w0), 64'd0);
        wait_done(300, td);
        check("stall_latency", 64'(td - t0), 64'd74);
        check("stall_queue_empty", 64'(exp_q.size()), 64'd0);

        // Maxpool write to word 5 during its CAP cycle forces a re-read.
        preload(0);
        for (int a = 0; a < NW; a++)
            exp_q.push_back('{a: AW'(a), d: (a == 5) ? DW'(32'hAB) : DW'(a + 1)});
        start_scan(t0);
        repeat (21) @(posedge clk);
        #1;
        mp_ena = 1'b1; mp_wea = 1'b1; mp_addr = AW'(5); mp_write = DW'(32'hAB);
        @(posedge clk); #1;
        mp_ena = 1'b0; mp_wea = 1'b0;
        wait_done(300, td);
        check("hazard_latency", 64'(td - t0), 64'd66);
        check("hazard_queue_empty", 64'(exp_q.size()), 64'd0);
        mp_rd(5, rd);
        check("hazard_mem5_cleared", 64'(rd), 64'd0);

        // Consumer back-pressure on the first word.
        preload(0);
        push_plain();
        oif.out_ready = 1'b0;
        start_scan(t0);
        vcnt = 0;
        for (int n = 0; n < 20 && !oif.out_valid; n++) @(negedge clk);
        check("bp_valid_reached", 64'(oif.out_valid), 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!oif.out_valid || oif.out_addr != AW'(0) || oif.out_data != DW'(1)) vcnt++;
        end
        check("bp_hold_stable", 64'(vcnt), 64'd0);
        @(posedge clk); #1;
        oif.out_ready = 1'b1;
        wait_done(300, td);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset while word 7 is in CAP abandons the scan.
        preload(0);
        for (int a = 0; a < 7; a++) exp_q.push_back('{a: AW'(a), d: DW'(a + 1)});
        start_scan(t0);
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b0;
        w0 = scan_wr;
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst");
        check("midrst_no_write", 64'(scan_wr - w0), 64'd0);
        check("midrst_queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        mp_rd(7, rd); check("midrst_mem7_kept", 64'(rd), 64'd8);
        mp_rd(6, rd); check("midrst_mem6_cleared", 64'(rd), 64'd0);
        for (int a = 0; a < NW; a++)
            exp_q.push_back('{a: AW'(a), d: (a < 7) ? DW'(0) : DW'(a + 1)});
        start_scan(t0);
        wait_done(200, td);
        check("rescan_latency", 64'(td - t0), 64'd64);
        check("rescan_queue_empty", 64'(exp_q.size()), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
